// File: rtl/fetch_sequencer.sv
// Fetch front end: generates fetch PCs, requests aligned I-cache blocks
// and hands fetch groups to the instruction queue.
// Ports:
//   clk, rst (async, active-low)
//   icache_req_*  : block request (valid/ready, aligned address)
//   icache_resp_* : one block of FETCH_WIDTH words per accepted request
//   bp_*          : combinational prediction for the current fetch PC
//   iq_*          : queue back-pressure in, flush pulse out
//   enq_*         : fetch group presented to the queue
//   redirect_*    : backend redirect; stall_cycles: saturating counter
module fetch_sequencer #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int unsigned QUEUE_DEPTH = 32,
  localparam int unsigned LW  = $clog2(FETCH_WIDTH),
  localparam int unsigned SW  = $clog2(QUEUE_DEPTH) + 1,
  localparam logic [31:0] BLK = 32'(FETCH_WIDTH * 4)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   icache_req_valid,
  output logic [31:0]            icache_req_addr,
  input  logic                   icache_req_ready,
  input  logic                   icache_resp_valid,
  input  logic [31:0]            icache_resp_data [FETCH_WIDTH],
  input  logic                   bp_taken,
  input  logic [LW-1:0]          bp_lane,
  input  logic [31:0]            bp_target,
  input  logic                   iq_fetch_stall,
  input  logic [SW-1:0]          iq_free_slots,
  output logic [31:0]            enq_insts [FETCH_WIDTH],
  output logic [31:0]            enq_pcs [FETCH_WIDTH],
  output logic [FETCH_WIDTH-1:0] enq_valid,
  output logic [LW:0]            enq_count,
  output logic                   enq_ready,
  output logic                   enq_predicted_taken,
  output logic [31:0]            enq_predicted_target,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   iq_flush,
  output logic [31:0]            stall_cycles
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DELIVER,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   fetch_pc;
  logic [31:0]   block_base;
  logic [31:0]   next_pc;
  logic [LW-1:0] start_lane;
  logic [LW-1:0] last_lane;
  logic          eff_taken;
  logic          req_fire;
  logic          in_deliver;

  logic [31:0]   base_q;
  logic [31:0]   target_q;
  logic [LW-1:0] start_q;
  logic [LW-1:0] last_q;
  logic          taken_q;
  logic          drop_q;
  logic [31:0]   buf_q [FETCH_WIDTH];

  always_comb begin
    block_base = fetch_pc & ~(BLK - 32'd1);
    start_lane = fetch_pc[LW+1:2];
    // A predicted branch before the entry point is not on our path.
    eff_taken  = bp_taken && (bp_lane >= start_lane);
    last_lane  = eff_taken ? bp_lane : LW'(FETCH_WIDTH - 1);
    next_pc    = eff_taken ? bp_target : block_base + BLK;
  end

  // Gated by rst so the request is quiet while reset is held.
  assign icache_req_valid = rst && (state_q == S_REQ) &&
                            !iq_fetch_stall && !redirect_valid;
  assign icache_req_addr  = block_base;
  assign req_fire         = icache_req_valid && icache_req_ready;

  always_comb begin
    in_deliver           = (state_q == S_DELIVER);
    enq_valid            = '0;
    enq_count            = '0;
    enq_predicted_taken  = 1'b0;
    enq_predicted_target = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      enq_insts[i] = '0;
      enq_pcs[i]   = '0;
      if (in_deliver && LW'(i) >= start_q && LW'(i) <= last_q) begin
        enq_valid[i] = 1'b1;
        enq_insts[i] = buf_q[i];
        enq_pcs[i]   = base_q + 32'(4 * i);
      end
    end
    if (in_deliver) begin
      enq_count = (LW+1)'(last_q) - (LW+1)'(start_q) + (LW+1)'(1);
      enq_predicted_taken  = taken_q;
      enq_predicted_target = taken_q ? target_q : '0;
    end
    enq_ready = in_deliver && !redirect_valid && !iq_flush &&
                (32'(iq_free_slots) >= 32'(enq_count));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ:
        if (req_fire) state_d = S_WAIT;
      S_WAIT:
        // A response landing with the redirect closes the request.
        if (redirect_valid)
          state_d = icache_resp_valid ? S_REQ : S_DRAIN;
        else if (icache_resp_valid)
          state_d = S_DELIVER;
      S_DELIVER:
        if (redirect_valid || enq_ready) state_d = S_REQ;
      S_DRAIN:
        if (icache_resp_valid && drop_q) state_d = S_REQ;
      default:
        state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_REQ;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc     <= RESET_PC;
      base_q       <= '0;
      target_q     <= '0;
      start_q      <= '0;
      last_q       <= '0;
      taken_q      <= 1'b0;
      drop_q       <= 1'b0;
      iq_flush     <= 1'b0;
      stall_cycles <= '0;
    end else begin
      iq_flush <= redirect_valid;
      if (redirect_valid)
        fetch_pc <= redirect_pc;
      else if (req_fire)
        fetch_pc <= next_pc;
      if (req_fire) begin
        base_q   <= block_base;
        start_q  <= start_lane;
        last_q   <= last_lane;
        taken_q  <= eff_taken;
        target_q <= bp_target;
      end
      if (state_q == S_WAIT && redirect_valid && !icache_resp_valid)
        drop_q <= 1'b1;
      else if (state_q == S_DRAIN && icache_resp_valid)
        drop_q <= 1'b0;
      if (state_q == S_REQ && iq_fetch_stall &&
          stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FETCH_WIDTH; i++) buf_q[i] <= '0;
    end else if (state_q == S_WAIT && icache_resp_valid &&
                 !redirect_valid) begin
      for (int i = 0; i < FETCH_WIDTH; i++) buf_q[i] <= icache_resp_data[i];
    end
  end

  a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst)
    !(icache_resp_valid && (state_q == S_REQ || state_q == S_DELIVER)));

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Front-end controller that generates fetch PCs, issues aligned block requests to the I-cache, and delivers fetch groups into the instruction queue. It applies branch-predictor redirects, honours the queue's back-pressure (`fetch_stall`, `free_slots`), and handles backend redirects. On a redirect it flushes the queue and discards stale in-flight cache responses. It sits between the branch predictor/I-cache and the instruction queue.

Parameters:
- FETCH_WIDTH, 4, instructions per fetch block. Power of two; block size is FETCH_WIDTH*4 bytes, aligned.
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- QUEUE_DEPTH, 32, depth of the downstream queue. Sets the width of `iq_free_slots`.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- icache_req_valid  out  1  request valid.
- icache_req_addr  out  32  block-aligned request address.
- icache_req_ready  in  1  cache accepts the request this cycle.
- icache_resp_valid  in  1  response valid; at most one response per accepted request.
- icache_resp_data  in  FETCH_WIDTH x 32 (unpacked)  block instruction words; lane i is at block_base+4i.
- bp_taken  in  1  combinational prediction for the current fetch PC.
- bp_lane  in  $clog2(FETCH_WIDTH)  lane of the predicted-taken branch.
- bp_target  in  32  predicted target.
- iq_fetch_stall  in  1  queue almost-full.
- iq_free_slots  in  $clog2(QUEUE_DEPTH)+1  free queue entries.
- enq_insts  out  FETCH_WIDTH x 32  group instructions.
- enq_pcs  out  FETCH_WIDTH x 32  group PCs.
- enq_valid  out  FETCH_WIDTH  lane valid mask.
- enq_count  out  $clog2(FETCH_WIDTH)+1  popcount of `enq_valid`.
- enq_ready  out  1  group is presented and accepted this cycle.
- enq_predicted_taken  out  1  group ends in a predicted-taken branch.
- enq_predicted_target  out  32  target of that branch.
- redirect_valid  in  1  backend redirect (mispredict or exception).
- redirect_pc  in  32  new fetch PC.
- iq_flush  out  1  queue flush pulse.
- stall_cycles  out  32  saturating count of cycles spent in REQ with the request blocked by `iq_fetch_stall`.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=REQ, fetch_pc=RESET_PC, drop=0, stall_cycles=0.
  - All outputs 0, except `icache_req_addr`, which follows fetch_pc.
- Combinational lane/next-PC rules, computed on fetch_pc:
  - block_base = fetch_pc with the low $clog2(FETCH_WIDTH)+2 bits cleared.
  - start = fetch_pc[$clog2(FETCH_WIDTH)+1:2].
  - eff_taken = bp_taken && bp_lane >= start.
  - last = eff_taken ? bp_lane : FETCH_WIDTH-1.
  - next_pc = eff_taken ? bp_target : block_base + FETCH_WIDTH*4, with 32-bit wrap.
- State REQ:
  - `icache_req_valid` = !iq_fetch_stall && !redirect_valid; `icache_req_addr` = block_base.
  - On handshake: latch base, start, last, eff_taken and bp_target; fetch_pc <= next_pc; go to WAIT.
  - A stalled cycle increments `stall_cycles`.
- State WAIT:
  - On `icache_resp_valid`: capture the data into the group buffer and go to DELIVER.
  - Lanes start..last are valid; PC of lane i = base + 4i.
- State DELIVER:
  - Outputs are driven from the buffer.
  - `enq_ready` = (iq_free_slots >= enq_count) && !redirect_valid.
  - When `enq_ready` is 1, the group is consumed and the state goes to REQ in the next cycle.
  - Otherwise hold the group with outputs stable.
  - At most one group is in flight; delivery latency is handshake + response + 1 cycle.
- Redirect (`redirect_valid`) has highest priority in every state:
  - fetch_pc <= redirect_pc, and `iq_flush` = 1 in the next cycle only (registered).
  - `enq_ready` is forced to 0 in the redirect cycle and in the flush cycle.
  - If a request is outstanding (WAIT, or REQ with a handshake in the same cycle): set drop=1 and go to DRAIN.
  - Otherwise go to REQ. The REQ request is suppressed in the redirect cycle.
- State DRAIN:
  - No request is issued.
  - On `icache_resp_valid`: discard the response, drop=0, go to REQ.
  - A further redirect during DRAIN only updates fetch_pc.
- `enq_count`: 0 when not in DELIVER.
- `enq_valid`: lanes outside start..last are 0. Their `enq_insts`/`enq_pcs` are 0.
- A response arriving in REQ or DELIVER is a protocol violation (assertion); it must not corrupt state.
- `stall_cycles` saturates at 32'hFFFF_FFFF.
- Reset asserted mid-transaction returns immediately to the reset values. Any later stale response is ignored because the state is REQ.

Test Plan:
1. Reset, then ready=1 with 1-cycle response latency and no prediction.
   - Request addresses are BFC0_0000, BFC0_0010, BFC0_0020.
   - Each group has enq_valid=4'b1111, enq_count=4.
   - enq_pcs of the first group are BFC0_0000..BFC0_000C.
2. Redirect to 0x0000_0108.
   - Next request addr=0x100, enq_valid=4'b1100, enq_count=2, pcs 0x108/0x10C.
   - iq_flush is pulsed exactly one cycle after the redirect.
3. At fetch_pc 0x200, bp_taken=1, bp_lane=1, bp_target=0x400.
   - enq_valid=4'b0011, enq_predicted_taken=1, enq_predicted_target=0x400; next request addr=0x400.
   - Repeat with bp_lane=0 at fetch_pc 0x208: the prediction is ignored, enq_valid=4'b1100, next request 0x210.
4. iq_fetch_stall=1 for 5 cycles in REQ.
   - icache_req_valid=0 throughout; stall_cycles=5; fetching resumes the cycle after the stall drops.
   - Separately, iq_free_slots=2 with a 4-lane group: enq_ready=0 and the group is held stable until free_slots=4.
5. Redirect to 0x800 while in WAIT; the stale response arrives 3 cycles later.
   - The stale response is discarded, with no enq_ready.
   - The next request is addr 0x800.
6. Drop rst low asynchronously during DELIVER.
   - Outputs go to 0 without a clock edge.
   - After release, the first request addr is BFC0_0000.
